// File: rtl/cpu_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Brief    : Loads a program into instruction memory, then sequences the CPU
//            through run / single-step / pause / halt with a cycle watchdog.
// Revision : 1.0
// ============================================================================
module cpu_run_controller #(
    parameter int unsigned MAX_CYCLES = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       host_valid,
    input  logic [3:0] host_data,
    input  logic       host_last,
    output logic       host_ready,
    input  logic       cmd_run,
    input  logic       cmd_step,
    input  logic       cmd_stop,
    input  logic       cmd_load,
    input  logic [2:0] cpu_opcode,
    output logic       imem_we,
    output logic [3:0] imem_addr,
    output logic [3:0] imem_wdata,
    output logic       cpu_reset,
    output logic       cpu_clk_en,
    output logic [2:0] state,
    output logic [4:0] prog_len,
    output logic [7:0] cycle_count,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_READY  = 3'd2,
        S_RUN    = 3'd3,
        S_STEP   = 3'd4,
        S_PAUSED = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam logic [2:0] c_hlt_opcode = 3'b111;
    localparam logic [7:0] c_max_cycles = MAX_CYCLES[7:0];
    localparam logic [4:0] c_last_slot  = 5'd15;

    state_t     r_state;
    logic       r_imem_we;
    logic [3:0] r_imem_addr;
    logic [3:0] r_imem_wdata;
    logic [4:0] r_prog_len;
    logic [7:0] r_cycle_count;
    logic       r_done;
    logic       r_timeout;

    logic       w_halt_op;
    logic       w_clk_en;
    logic       w_accept;
    logic       w_watchdog;
    logic [7:0] w_cc_next;

    // HLT is decoded combinationally so the halting instruction never gets an enable.
    assign w_halt_op  = (cpu_opcode == c_hlt_opcode);
    assign w_clk_en   = ((r_state == S_RUN) || (r_state == S_STEP)) && !w_halt_op;
    assign host_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_accept   = host_ready && host_valid;
    assign w_cc_next  = (r_cycle_count == 8'hFF) ? 8'hFF : r_cycle_count + 8'd1;
    // ">=" keeps the watchdog armed even if single-steps already pushed the count past the limit.
    assign w_watchdog = (r_state == S_RUN) && w_clk_en && (w_cc_next >= c_max_cycles);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_imem_we     <= 1'b0;
            r_imem_addr   <= 4'd0;
            r_imem_wdata  <= 4'd0;
            r_prog_len    <= 5'd0;
            r_cycle_count <= 8'd0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_imem_we <= 1'b0;
            if (w_clk_en) begin
                r_cycle_count <= w_cc_next;
            end
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_prog_len[3:0];
                        r_imem_wdata <= host_data;
                        r_prog_len   <= r_prog_len + 5'd1;
                        r_state      <= (host_last || (r_prog_len == c_last_slot)) ? S_READY : S_LOAD;
                    end
                end
                S_READY, S_PAUSED: begin
                    if (cmd_step) begin
                        r_state <= S_STEP;
                    end else if (cmd_run) begin
                        r_state <= S_RUN;
                        if (r_state == S_READY) begin
                            r_cycle_count <= 8'd0;
                            r_timeout     <= 1'b0;
                        end
                    end else if (cmd_load) begin
                        r_state       <= S_IDLE;
                        r_prog_len    <= 5'd0;
                        r_cycle_count <= 8'd0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cmd_stop) begin
                        r_state <= S_PAUSED;
                    end else if (w_halt_op) begin
                        r_state <= S_HALTED;
                        r_done  <= 1'b1;
                    end else if (w_watchdog) begin
                        r_state   <= S_HALTED;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                S_STEP: begin
                    if (w_halt_op) begin
                        r_state <= S_HALTED;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_PAUSED;
                    end
                end
                S_HALTED: begin
                    if (cmd_run) begin
                        r_state <= S_READY;
                        r_done  <= 1'b0;
                    end else if (cmd_load) begin
                        r_state       <= S_IDLE;
                        r_prog_len    <= 5'd0;
                        r_cycle_count <= 8'd0;
                        r_done        <= 1'b0;
                        r_timeout     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign imem_we     = r_imem_we;
    assign imem_addr   = r_imem_addr;
    assign imem_wdata  = r_imem_wdata;
    assign prog_len    = r_prog_len;
    assign cycle_count = r_cycle_count;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cpu_clk_en  = w_clk_en;
    assign cpu_reset   = !((r_state == S_RUN) || (r_state == S_STEP) || (r_state == S_PAUSED));

endmodule
`default_nettype wire

// File: doc/cpu_run_controller.md
CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 Parameter MAX_CYCLES SHALL be: default 200; enabled-cycle watchdog limit, legal range 1..255.
REQ-002 Port clk SHALL be: input, 1 bit; rising-edge clock.
REQ-003 Port reset SHALL be: input, 1 bit; asynchronous, active-high.
REQ-004 Port host_valid SHALL be: input, 1 bit; host program word valid.
REQ-005 Port host_data SHALL be: input, 4 bits; program word.
REQ-006 Port host_last SHALL be: input, 1 bit; qualifies the final program word.
REQ-007 Port host_ready SHALL be: output, 1 bit; controller accepts a program word.
REQ-008 Ports cmd_run, cmd_step, cmd_stop, cmd_load SHALL be: inputs, 1 bit each; single-cycle command pulses.
REQ-009 Port cpu_opcode SHALL be: input, 3 bits; opcode field of the CPU's current instruction.
REQ-010 Ports imem_we, imem_addr, imem_wdata SHALL be: outputs, 1/4/4 bits; instruction-memory write port.
REQ-011 Port cpu_reset SHALL be: output, 1 bit; active-high reset driven to the CPU.
REQ-012 Port cpu_clk_en SHALL be: output, 1 bit; CPU advances one instruction on each clk edge where it is 1.
REQ-013 Port state SHALL be: output, 3 bits; current FSM state encoding.
REQ-014 Ports prog_len, cycle_count SHALL be: outputs, 5/8 bits; words loaded (0..16) and enabled-cycle count.
REQ-015 Ports done, timeout SHALL be: outputs, 1 bit each; halt reached; watchdog expired.

Function
REQ-016 State encodings SHALL be IDLE=0, LOAD=1, READY=2, RUN=3, STEP=4, PAUSED=5, HALTED=6.
REQ-017 host_ready SHALL be 1 in IDLE and LOAD only; a word is accepted on a clk edge with host_valid=1 and host_ready=1.
REQ-018 An accepted word SHALL produce imem_we=1 for exactly the following cycle, with imem_wdata=word and imem_addr=prog_len before the accept.
REQ-019 Each accept SHALL increment prog_len; IDLE SHALL move to LOAD on the first accept.
REQ-020 Accepting a word with host_last=1, or the 16th word, SHALL move to READY; words beyond 16 SHALL NOT be accepted.
REQ-021 cpu_reset SHALL be 1 in IDLE, LOAD, READY and HALTED, and 0 in RUN, STEP and PAUSED.
REQ-022 cpu_clk_en SHALL be combinational: 1 iff state is RUN or STEP and cpu_opcode != 3'b111, so HLT never executes.
REQ-023 READY or PAUSED with cmd_run SHALL move to RUN; READY additionally SHALL clear cycle_count and timeout.
REQ-024 READY or PAUSED with cmd_step SHALL move to STEP; STEP SHALL last one cycle and then move to PAUSED.
REQ-025 RUN with cmd_stop SHALL move to PAUSED; cmd_stop outside RUN SHALL be ignored.
REQ-026 RUN or STEP with cpu_opcode=3'b111 SHALL move to HALTED, where done=1.
REQ-027 cycle_count SHALL increment on every edge with cpu_clk_en=1 and saturate at 255.
REQ-028 In RUN, an edge where cycle_count reaches MAX_CYCLES SHALL move to HALTED with timeout=1 (sticky until READY->RUN or reset).
REQ-029 HALTED with cmd_run SHALL move to READY, retaining program and prog_len.
REQ-030 cmd_load in READY, PAUSED or HALTED SHALL move to IDLE and clear prog_len, done, timeout and cycle_count.
REQ-031 Commands SHALL be ignored in IDLE, LOAD and STEP, and cmd_step SHALL be ignored in RUN.
REQ-032 Simultaneous commands SHALL resolve by priority: cmd_stop > halt/timeout > cmd_step > cmd_run > cmd_load.
REQ-033 host_valid outside IDLE/LOAD SHALL have no effect.

Reset
REQ-034 On reset SHALL force: state=IDLE, prog_len=0, cycle_count=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, cpu_clk_en=0, done=0, timeout=0, host_ready=1.
REQ-035 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation with no further imem_we pulse.

Verification
REQ-036 Load 3 words 4'h1, 4'h3, 4'hE (last on 3rd) -> imem_we pulses at addrs 0, 1, 2 with matching data; prog_len=3; state=READY.
REQ-037 Stream 17 words with no host_last -> 16 writes at addrs 0..15; host_ready=0 after the 16th; state=READY.
REQ-038 cmd_run; cpu_opcode=3'b001 for 5 cycles, then 3'b111 -> cycle_count=5, cpu_clk_en=0 on the HLT cycle, state=HALTED, done=1.
REQ-039 From READY, cmd_step twice -> exactly 2 cpu_clk_en pulses, state=PAUSED, cpu_reset=0, cycle_count=2.
REQ-040 MAX_CYCLES=10; cmd_run with no HLT -> HALTED after 10 enabled cycles, timeout=1; cmd_stop and cmd_run on the same edge in RUN -> PAUSED.
REQ-041 Reset asserted during RUN -> state=IDLE, cpu_reset=1, prog_len=0 immediately (asynchronous).
